// File: rtl/mem_access_arbiter_pkg.sv
// Shared encodings and the alignment rule for the two-requester RAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [1:0] DL_BYTE   = 2'b00;
    localparam logic [1:0] DL_HALF   = 2'b01;
    localparam logic [1:0] DL_WORD   = 2'b10;
    localparam logic [1:0] DL_DOUBLE = 2'b11;

    localparam logic OWN_CU = 1'b0;
    localparam logic OWN_LD = 1'b1;

    localparam int unsigned CNT_W = 3;

    // An access must start on a boundary of its own size.
    function automatic logic is_misaligned(input logic [1:0] dl, input logic [2:0] addr_lo);
        logic mis;
        case (dl)
            DL_HALF:   mis = addr_lo[0];
            DL_WORD:   mis = |addr_lo[1:0];
            DL_DOUBLE: mis = |addr_lo;
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_wait_counter.sv
// Down-counter that times the RAM access phase; zero marks the final access cycle.
module wait_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(WAIT_STATES);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one RAM port between the control unit and the program loader.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cu_mov,
    input  logic              cu_rw,
    input  logic [1:0]        cu_dl,
    input  logic [ADDR_W-1:0] cu_addr,
    input  logic [31:0]       cu_wdata,
    output logic              cu_moc,
    output logic [31:0]       cu_rdata,
    input  logic              ld_req,
    input  logic              ld_rw,
    input  logic [1:0]        ld_dl,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ack,
    output logic [31:0]       ld_rdata,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [1:0]        ram_dl,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              err,
    output logic              owner,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic              owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              ram_en_q, ram_en_d;
    logic              cu_moc_q, cu_moc_d;
    logic              ld_ack_q, ld_ack_d;
    logic              err_q, err_d;
    logic              rw_q, rw_d;
    logic [1:0]        dl_q, dl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       cu_rdata_q, cu_rdata_d;
    logic [31:0]       ld_rdata_q, ld_rdata_d;

    logic              grant_ld;
    logic              sel_rw;
    logic [1:0]        sel_dl;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              cnt_load, cnt_dec, cnt_zero;

    wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        busy_d       = busy_q;
        ram_en_d     = ram_en_q;
        cu_moc_d     = cu_moc_q;
        ld_ack_d     = ld_ack_q;
        err_d        = err_q;
        rw_d         = rw_q;
        dl_d         = dl_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cu_rdata_d   = cu_rdata_q;
        ld_rdata_d   = ld_rdata_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        // Loader wins when alone, or on a tie when the CU was served last.
        grant_ld  = ld_req && (!cu_mov || (last_owner_q == OWN_CU));
        sel_rw    = grant_ld ? ld_rw    : cu_rw;
        sel_dl    = grant_ld ? ld_dl    : cu_dl;
        sel_addr  = grant_ld ? ld_addr  : cu_addr;
        sel_wdata = grant_ld ? ld_wdata : cu_wdata;

        unique case (state_q)
            ST_IDLE: begin
                if (cu_mov || ld_req) begin
                    owner_d = grant_ld ? OWN_LD : OWN_CU;
                    busy_d  = 1'b1;
                    rw_d    = sel_rw;
                    dl_d    = sel_dl;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    if (is_misaligned(sel_dl, sel_addr[2:0])) begin
                        state_d  = ST_DONE;
                        err_d    = 1'b1;
                        cu_moc_d = !grant_ld;
                        ld_ack_d = grant_ld;
                    end else begin
                        state_d  = ST_ACCESS;
                        ram_en_d = 1'b1;
                        cnt_load = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_zero) begin
                    state_d  = ST_DONE;
                    ram_en_d = 1'b0;
                    cu_moc_d = (owner_q == OWN_CU);
                    ld_ack_d = (owner_q == OWN_LD);
                    if (rw_q) begin
                        if (owner_q == OWN_LD) ld_rdata_d = ram_rdata;
                        else                   cu_rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                if (!((owner_q == OWN_LD) ? ld_req : cu_mov)) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    busy_d       = 1'b0;
                    cu_moc_d     = 1'b0;
                    ld_ack_d     = 1'b0;
                    err_d        = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_LD;
            owner_q      <= OWN_CU;
            busy_q       <= 1'b0;
            ram_en_q     <= 1'b0;
            cu_moc_q     <= 1'b0;
            ld_ack_q     <= 1'b0;
            err_q        <= 1'b0;
            rw_q         <= 1'b0;
            dl_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cu_rdata_q   <= '0;
            ld_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            ram_en_q     <= ram_en_d;
            cu_moc_q     <= cu_moc_d;
            ld_ack_q     <= ld_ack_d;
            err_q        <= err_d;
            rw_q         <= rw_d;
            dl_q         <= dl_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cu_rdata_q   <= cu_rdata_d;
            ld_rdata_q   <= ld_rdata_d;
        end
    end

    assign cu_moc    = cu_moc_q;
    assign cu_rdata  = cu_rdata_q;
    assign ld_ack    = ld_ack_q;
    assign ld_rdata  = ld_rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_rw    = rw_q;
    assign ram_dl    = dl_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign err       = err_q;
    assign owner     = owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed scenarios plus random rounds against a transaction-level model.
module tb_mem_access_arbiter;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cu_mov, cu_rw, ld_req, ld_rw;
    logic [1:0]  cu_dl, ld_dl;
    logic [7:0]  cu_addr, ld_addr;
    logic [31:0] cu_wdata, ld_wdata;
    logic        cu_moc, ld_ack, ram_en, ram_rw, err, owner, busy;
    logic [31:0] cu_rdata, ld_rdata, ram_wdata;
    logic [1:0]  ram_dl;
    logic [7:0]  ram_addr;
    logic [31:0] rd_pattern;

    logic        b_cu_mov, b_cu_rw;
    logic [1:0]  b_cu_dl;
    logic [7:0]  b_cu_addr;
    logic        b_cu_moc, b_ld_ack, b_ram_en, b_ram_rw, b_err, b_owner, b_busy;
    logic [31:0] b_cu_rdata, b_ld_rdata, b_ram_wdata;
    logic [1:0]  b_ram_dl;
    logic [7:0]  b_ram_addr;

    always #5 clk = ~clk;

    mem_access_arbiter #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(rst_n),
        .cu_mov(cu_mov), .cu_rw(cu_rw), .cu_dl(cu_dl), .cu_addr(cu_addr), .cu_wdata(cu_wdata),
        .cu_moc(cu_moc), .cu_rdata(cu_rdata),
        .ld_req(ld_req), .ld_rw(ld_rw), .ld_dl(ld_dl), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .ram_en(ram_en), .ram_rw(ram_rw), .ram_dl(ram_dl), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(rd_pattern),
        .err(err), .owner(owner), .busy(busy)
    );

    mem_access_arbiter #(.ADDR_W(8), .WAIT_STATES(0)) dut_b (
        .clk(clk), .reset(rst_n),
        .cu_mov(b_cu_mov), .cu_rw(b_cu_rw), .cu_dl(b_cu_dl), .cu_addr(b_cu_addr), .cu_wdata(32'h0),
        .cu_moc(b_cu_moc), .cu_rdata(b_cu_rdata),
        .ld_req(1'b0), .ld_rw(1'b0), .ld_dl(2'b00), .ld_addr(8'h00), .ld_wdata(32'h0),
        .ld_ack(b_ld_ack), .ld_rdata(b_ld_rdata),
        .ram_en(b_ram_en), .ram_rw(b_ram_rw), .ram_dl(b_ram_dl), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(rd_pattern),
        .err(b_err), .owner(b_owner), .busy(b_busy)
    );

    int tests = 0;
    int failed = 0;

    // RAM-side monitor: counts enabled cycles and remembers the fields presented.
    int          en_cnt = 0, b_en_cnt = 0, chg_cnt = 0;
    logic        mon_rw, prev_en = 1'b0;
    logic [1:0]  mon_dl;
    logic [7:0]  mon_addr;
    logic [31:0] mon_wd;
    always @(negedge clk) begin
        if (ram_en) begin
            if (prev_en && ({ram_rw, ram_dl, ram_addr, ram_wdata} != {mon_rw, mon_dl, mon_addr, mon_wd}))
                chg_cnt++;
            en_cnt++;
            mon_rw = ram_rw; mon_dl = ram_dl; mon_addr = ram_addr; mon_wd = ram_wdata;
        end
        prev_en = ram_en;
        if (b_ram_en) b_en_cnt++;
    end

    // Transaction-level model state
    logic        q_rw[2];
    logic [1:0]  q_dl[2];
    logic [7:0]  q_addr[2];
    logic [31:0] q_wd[2];
    logic [31:0] exp_rd[2];
    bit          last_served;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit misaligned(input logic [1:0] dl, input logic [7:0] addr);
        int size;
        size = 1 << dl;
        return (int'(addr) % size) != 0;
    endfunction

    task automatic drive_fields();
        cu_rw = q_rw[0]; cu_dl = q_dl[0]; cu_addr = q_addr[0]; cu_wdata = q_wd[0];
        ld_rw = q_rw[1]; ld_dl = q_dl[1]; ld_addr = q_addr[1]; ld_wdata = q_wd[1];
    endtask

    task automatic txn(input string tag, input bit cu_on, input bit ld_on, input bit scramble, input bit drop_mid);
        bit win, mis, got;
        int en0, edges;
        win = (cu_on && ld_on) ? ~last_served : ld_on;
        mis = misaligned(q_dl[win], q_addr[win]);
        en0 = en_cnt;
        drive_fields();
        cu_mov = cu_on; ld_req = ld_on;
        edges = 0; got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1 && scramble) begin
                cu_rw = ~cu_rw; cu_dl = 2'($urandom); cu_addr = 8'($urandom); cu_wdata = $urandom;
                ld_rw = ~ld_rw; ld_dl = 2'($urandom); ld_addr = 8'($urandom); ld_wdata = $urandom;
            end
            if (edges == 2 && drop_mid) begin cu_mov = 1'b0; ld_req = 1'b0; end
            got = cu_moc || ld_ack;
        end
        check({tag, "_latency"}, 32'(edges), mis ? 32'd1 : 32'(WS + 2));
        check({tag, "_moc_ack"}, {30'd0, cu_moc, ld_ack}, {30'd0, ~win, win});
        check({tag, "_err_owner_busy"}, {29'd0, err, owner, busy}, {29'd0, mis, win, 1'b1});
        check({tag, "_en_cycles"}, 32'(en_cnt - en0), mis ? 32'd0 : 32'(WS + 1));
        if (!mis) begin
            check({tag, "_ram_ctl"}, {22'd0, mon_rw, mon_dl, mon_addr}, {22'd0, q_rw[win], q_dl[win], q_addr[win]});
            check({tag, "_ram_wdata"}, mon_wd, q_wd[win]);
            if (q_rw[win]) exp_rd[win] = rd_pattern;
        end
        check({tag, "_cu_rdata"}, cu_rdata, exp_rd[0]);
        check({tag, "_ld_rdata"}, ld_rdata, exp_rd[1]);
        cu_mov = 1'b0; ld_req = 1'b0;
        @(posedge clk); #1;
        check({tag, "_release"}, {28'd0, busy, cu_moc, ld_ack, err}, 32'd0);
        last_served = win;
    endtask

    task automatic wait_any(output int edges);
        bit got;
        edges = 0; got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk); #1;
            edges++;
            got = cu_moc || ld_ack;
        end
    endtask

    initial begin
        int edges, b0;
        rst_n = 1'b0;
        cu_mov = 0; cu_rw = 0; cu_dl = 0; cu_addr = 0; cu_wdata = 0;
        ld_req = 0; ld_rw = 0; ld_dl = 0; ld_addr = 0; ld_wdata = 0;
        b_cu_mov = 0; b_cu_rw = 0; b_cu_dl = 0; b_cu_addr = 0;
        rd_pattern = 32'h0;
        exp_rd[0] = 0; exp_rd[1] = 0;
        last_served = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", {26'd0, ram_en, cu_moc, ld_ack, err, busy, owner}, 32'd0);
        check("reset_rdata", cu_rdata | ld_rdata, 32'd0);
        check("reset_fields", {21'd0, ram_rw, ram_dl, ram_addr} | ram_wdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Simultaneous requests right after reset: CU first, then loader.
        q_rw[0] = 1; q_dl[0] = 2; q_addr[0] = 8'h20; q_wd[0] = 32'h1111_2222;
        q_rw[1] = 0; q_dl[1] = 2; q_addr[1] = 8'h40; q_wd[1] = 32'hCAFE_F00D;
        rd_pattern = 32'h0BAD_CAFE;
        drive_fields();
        cu_mov = 1; ld_req = 1;
        wait_any(edges);
        check("tie_latency", 32'(edges), 32'(WS + 2));
        check("tie_first", {29'd0, cu_moc, ld_ack, owner}, {29'd0, 1'b1, 1'b0, 1'b0});
        exp_rd[0] = rd_pattern;
        check("tie_cu_rdata", cu_rdata, exp_rd[0]);
        cu_mov = 0;
        @(posedge clk); #1;
        check("rearb_idle_gap", {30'd0, busy, ld_ack}, 32'd0);
        @(posedge clk); #1;
        check("tie_second", {30'd0, busy, owner}, {30'd0, 1'b1, 1'b1});
        wait_any(edges);
        check("tie_ld_ack", {29'd0, ld_ack, cu_moc, err}, {29'd0, 1'b1, 1'b0, 1'b0});
        check("tie_ld_fields", {23'd0, mon_rw, mon_addr}, {23'd0, 1'b0, 8'h40});
        check("tie_ld_wdata", mon_wd, 32'hCAFE_F00D);
        ld_req = 0;
        @(posedge clk); #1;
        check("tie_release", {31'd0, busy}, 32'd0);
        last_served = 1'b1;

        // CU word read at 0x10
        q_rw[0] = 1; q_dl[0] = 2; q_addr[0] = 8'h10; q_wd[0] = 32'h0;
        rd_pattern = 32'hDEAD_BEEF;
        txn("cu_read", 1, 0, 0, 0);
        check("cu_read_value", cu_rdata, 32'hDEAD_BEEF);

        // Loader misaligned half write
        q_rw[1] = 0; q_dl[1] = 1; q_addr[1] = 8'h03; q_wd[1] = 32'h5555_AAAA;
        txn("ld_misaligned", 0, 1, 0, 0);

        // CU drops its request during ACCESS
        q_rw[0] = 1; q_dl[0] = 0; q_addr[0] = 8'h21; rd_pattern = 32'h1234_5678;
        txn("cu_drop", 1, 0, 0, 1);

        // Zero-wait-state instance: double-word read at 0x08
        b0 = b_en_cnt;
        b_cu_rw = 1; b_cu_dl = 2'b11; b_cu_addr = 8'h08; b_cu_mov = 1;
        rd_pattern = 32'hA5A5_0F0F;
        edges = 0;
        for (int i = 0; i < 20 && !b_cu_moc; i++) begin
            @(posedge clk); #1;
            edges++;
        end
        check("ws0_latency", 32'(edges), 32'd2);
        check("ws0_en_cycles", 32'(b_en_cnt - b0), 32'd1);
        check("ws0_rdata", b_cu_rdata, 32'hA5A5_0F0F);
        b_cu_mov = 0;
        @(posedge clk); #1;
        check("ws0_release", {30'd0, b_busy, b_cu_moc}, 32'd0);

        // Random rounds
        for (int r = 0; r < 40; r++) begin
            bit con, lon;
            con = 1'($urandom); lon = 1'($urandom);
            if (!con && !lon) con = 1'b1;
            for (int k = 0; k < 2; k++) begin
                q_rw[k] = 1'($urandom); q_dl[k] = 2'($urandom);
                q_addr[k] = 8'($urandom); q_wd[k] = $urandom;
                if ($urandom_range(0, 2) != 0) q_addr[k] = q_addr[k] & 8'hF8;
            end
            rd_pattern = $urandom;
            txn($sformatf("rnd%0d", r), con, lon, 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Reset in the second ACCESS cycle
        q_rw[0] = 1; q_dl[0] = 2; q_addr[0] = 8'h30; rd_pattern = 32'h7777_8888;
        drive_fields();
        cu_mov = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_en", {31'd0, ram_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ctl", {26'd0, ram_en, cu_moc, ld_ack, err, busy, owner}, 32'd0);
        check("async_reset_data", cu_rdata | ld_rdata | ram_wdata | {24'd0, ram_addr}, 32'd0);
        cu_mov = 0;
        @(posedge clk); #1;
        check("reset_no_moc", {31'd0, cu_moc}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        exp_rd[0] = 0; exp_rd[1] = 0; last_served = 1'b1;
        q_addr[0] = 8'h34; rd_pattern = 32'h9999_0001;
        txn("post_reset", 1, 0, 0, 0);

        check("fields_stable_in_access", 32'(chg_cnt), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM byte-address width.
REQ-002 SHALL have parameter WAIT_STATES, default 2, extra RAM cycles per access (legal 0..7).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port cu_mov  input  1  control-unit memory request (MOV).
REQ-006 SHALL have port cu_rw  input  1  control-unit direction, 1 = read, 0 = write.
REQ-007 SHALL have port cu_dl  input  2  control-unit data length, 00 byte, 01 half, 10 word, 11 double word.
REQ-008 SHALL have port cu_addr  input  ADDR_W  control-unit address.
REQ-009 SHALL have port cu_wdata  input  32  control-unit write data.
REQ-010 SHALL have port cu_moc  output  1  memory-operation-complete to control unit.
REQ-011 SHALL have port cu_rdata  output  32  read data to control unit.
REQ-012 SHALL have ports ld_req, ld_rw, ld_dl, ld_addr, ld_wdata, ld_ack, ld_rdata: the program-loader requester, same widths and meanings as the cu_* ports (ld_req = cu_mov, ld_ack = cu_moc).
REQ-013 SHALL have port ram_en  output  1  RAM enable.
REQ-014 SHALL have ports ram_rw (1), ram_dl (2), ram_addr (ADDR_W), ram_wdata (32), all outputs: the granted request's fields.
REQ-015 SHALL have port ram_rdata  input  32  RAM read data.
REQ-016 SHALL have port err  output  1  alignment error, valid while moc/ack is high.
REQ-017 SHALL have port owner  output  1  current grant, 0 = CU, 1 = loader; valid when busy = 1.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-020 IDLE: on an edge with cu_mov or ld_req high, SHALL grant one requester, latch its rw/dl/addr/wdata, and go to ACCESS.
REQ-021 Tie (both requesting) SHALL go to the requester that was not last_owner (round-robin); single requester SHALL always win.
REQ-022 Grant SHALL be misaligned when dl = half with addr[0] != 0, word with addr[1:0] != 0, or double with addr[2:0] != 0; a misaligned grant SHALL skip ACCESS, go directly to DONE with err = 1, and never assert ram_en.
REQ-023 ACCESS: ram_en SHALL be high with the latched fields for exactly WAIT_STATES+1 cycles, timed by a down-counter loaded with WAIT_STATES.
REQ-024 On the final ACCESS edge, read data SHALL be captured from ram_rdata into the owner's rdata register; the FSM SHALL then enter DONE.
REQ-025 DONE: the owner's moc/ack SHALL be high, the other requester's low; the FSM SHALL stay in DONE until the owner's request is low, then go to IDLE and update last_owner.
REQ-026 Latency: moc/ack SHALL rise WAIT_STATES+2 edges after the edge that sampled the request (1 edge for a misaligned grant).
REQ-027 A request dropped during ACCESS SHALL NOT abort the access; DONE SHALL then last exactly one cycle.
REQ-028 Request-field changes after the grant SHALL be ignored until the next IDLE.
REQ-029 A request still high when DONE exits SHALL be re-arbitrated normally and SHALL NOT be granted in the same cycle.
REQ-030 cu_rdata/ld_rdata SHALL hold their last captured value until the next read by the same requester.

Reset
REQ-031 reset low SHALL asynchronously force IDLE, counter 0, last_owner = loader (so CU wins the first tie), and ram_en, cu_moc, ld_ack, err, busy, owner, rdata registers, and latched fields to 0.
REQ-032 Reset during ACCESS SHALL drop ram_en immediately, with no moc/ack for the aborted access.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state encoding, DL encodings, owner encodings, and the alignment-check function.
REQ-034 Wait timing SHALL be implemented in one sub-module, wait_counter (load, decrement, zero flag).

Verification
REQ-035 CU read, addr 0x10, dl = word, WAIT_STATES = 2, ram_rdata = 0xDEADBEEF -> ram_en high for 3 cycles, cu_moc rises on the 4th edge, cu_rdata = 0xDEADBEEF.
REQ-036 cu_mov and ld_req both rise after reset -> CU granted first; loader granted in the next IDLE; owner sequence 0 then 1.
REQ-037 Loader write, addr 0x03, dl = half -> err = 1 and ld_ack high 1 edge after the request, with ram_en never asserted.
REQ-038 cu_mov dropped mid-ACCESS -> access completes, cu_moc is high for exactly 1 cycle, FSM returns to IDLE.
REQ-039 reset asserted in the 2nd ACCESS cycle -> ram_en falls without waiting for a clock edge, all outputs read 0, and a new cu_mov is then served normally.
REQ-040 WAIT_STATES = 0, CU double-word read, addr 0x08 -> ram_en high 1 cycle, cu_moc on the 2nd edge.
